// File: rtl/csr_bank_pkg.sv
// Shared CSR bank definitions: op encodings, FSM states, counter addresses, ROM-region test.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package csr_pkg;

    // CSR instruction op field; 00 is reserved and always rejected
    typedef enum logic [1:0] {
        CSR_OP_ILL = 2'b00,
        CSR_OP_RW  = 2'b01,
        CSR_OP_RS  = 2'b10,
        CSR_OP_RC  = 2'b11
    } csr_op_e;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } csr_state_e;

    // Machine-mode counters (writable) and their user-mode read-only shadows
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

    // The top two address bits equal to 11 mark a read-only CSR
    function automatic logic csr_is_rom(input logic [1:0] i_top2);
        return (i_top2 == 2'b11);
    endfunction

endpackage

// File: rtl/csr_bank_if.sv
// Request/response bus between the core's execute stage and the CSR bank.
// Latency: n/a (wires only).
// Backpressure: req_valid/req_ready handshake; response is a one-cycle resp_valid pulse, no rdy.
interface csr_bank_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 12
);
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic              resp_valid;
    logic [XLEN-1:0]   resp_rdata;
    logic              resp_illegal;

    // Core side
    modport master (
        output req_valid, req_op, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_illegal
    );

    // CSR bank side
    modport slave (
        input  req_valid, req_op, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_illegal
    );
endinterface

// File: rtl/csr_bank_counter64.sv
// Two-half free-running counter with independent lo/hi write ports (mcycle / minstret).
// Latency: write or increment visible the cycle after the edge that applies it.
// Backpressure: none; a write to a half replaces that half's increment for the cycle.
//
// Ports: clk, rst (async, active-high); i_inc count enable; i_wr_lo/i_wr_hi half write strobes;
//        i_wdata value for whichever half is written; o_cnt {hi, lo}.
module csr_counter64 #(
    parameter int HALF_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_inc,
    input  logic                i_wr_lo,
    input  logic                i_wr_hi,
    input  logic [HALF_W-1:0]   i_wdata,
    output logic [2*HALF_W-1:0] o_cnt
);
    logic [HALF_W-1:0] r_lo;
    logic [HALF_W-1:0] r_hi;
    logic              w_carry;

    // A lo write cancels the lo increment, so it cannot produce a carry either
    assign w_carry = i_inc & ~i_wr_lo & (&r_lo);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lo <= '0;
            r_hi <= '0;
        end else begin
            if (i_wr_lo)
                r_lo <= i_wdata;
            else if (i_inc)
                r_lo <= r_lo + HALF_W'(1);

            if (i_wr_hi)
                r_hi <= i_wdata;
            else if (w_carry)
                r_hi <= r_hi + HALF_W'(1);
        end
    end

    assign o_cnt = {r_hi, r_lo};
endmodule

// File: rtl/csr_bank.sv
// RISC-V CSR bank: atomic CSRRW/CSRRS/CSRRC over a sync-read storage array, read-only region check.
// Latency: 2 cycles accept-to-resp_valid; one request every 2 cycles.
// Backpressure: req_ready low during EXEC; held req_valid is accepted on the next IDLE cycle.
//
// Ports: clk, rst (async, active-high); instret_inc retire strobe; bus (csr_bank_if.slave):
//        req_valid/req_ready/req_op/req_addr/req_wdata in, resp_valid/resp_rdata/resp_illegal out.
// Build option: CSR_COUNTERS_EN adds mcycle/minstret and their cycle/instret shadows; without it
//        those addresses are plain storage words and instret_inc is ignored.
module csr_bank
    import csr_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int ADDR_W     = 12,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     instret_inc,
    csr_bank_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    csr_state_e        r_state;
    csr_state_e        w_state_nxt;
    logic              w_req_ready;
    logic              w_exec;
    logic              w_accept;

    csr_op_e           r_op;
    logic [ADDR_W-1:0] r_addr;
    logic [XLEN-1:0]   r_wdata;

    logic [XLEN-1:0]   r_mem [DEPTH];
    logic [XLEN-1:0]   r_mem_rd;

    logic              w_cnt_hit;
    logic [XLEN-1:0]   w_cnt_val;

    logic [XLEN-1:0]   w_old;
    logic [XLEN-1:0]   w_new;
    logic              w_suppress;
    logic              w_wr_attempt;
    logic              w_illegal;
    logic              w_we;
    logic              w_mem_we;

    logic              r_resp_valid;
    logic [XLEN-1:0]   r_resp_rdata;
    logic              r_resp_illegal;

    logic              w_unused_ok;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_req_ready = 1'b0;
        w_exec      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_req_ready = 1'b1;
                if (bus.req_valid)
                    w_state_nxt = ST_EXEC;
            end
            ST_EXEC: begin
                w_exec      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_accept = w_req_ready & bus.req_valid;

    // ---------------- request capture ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op    <= CSR_OP_ILL;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_op    <= csr_op_e'(bus.req_op);
            r_addr  <= bus.req_addr;
            r_wdata <= bus.req_wdata;
        end
    end

    // ---------------- storage ----------------
    // No reset so this maps onto block RAM. The read is issued on accept and the only write
    // happens in EXEC, so a read never lands on the same edge as a write to its word.
    always_ff @(posedge clk) begin
        if (w_accept)
            r_mem_rd <= r_mem[bus.req_addr[DEPTH_LOG2-1:0]];
        if (w_mem_we)
            r_mem[r_addr[DEPTH_LOG2-1:0]] <= w_new;
    end

    // ---------------- read-modify-write ----------------
    always_comb begin
        w_old = w_cnt_hit ? w_cnt_val : r_mem_rd;
        case (r_op)
            CSR_OP_RS: w_new = w_old | r_wdata;
            CSR_OP_RC: w_new = w_old & ~r_wdata;
            default:   w_new = r_wdata;
        endcase
        // Set/clear with a zero mask is a pure read: no write, and legal even on read-only CSRs
        w_suppress   = ((r_op == CSR_OP_RS) || (r_op == CSR_OP_RC)) && (r_wdata == '0);
        w_wr_attempt = (r_op != CSR_OP_ILL) && !w_suppress;
        w_illegal    = (r_op == CSR_OP_ILL) ||
                       (csr_is_rom(r_addr[ADDR_W-1 -: 2]) && w_wr_attempt);
        // rst gating keeps an EXEC cut short by reset from touching state on a coincident edge
        w_we         = w_exec && w_wr_attempt && !w_illegal && !rst;
        w_mem_we     = w_we && !w_cnt_hit;
    end

    // ---------------- response ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_resp_valid   <= 1'b0;
            r_resp_rdata   <= '0;
            r_resp_illegal <= 1'b0;
        end else begin
            r_resp_valid <= w_exec;
            if (w_exec) begin
                r_resp_illegal <= w_illegal;
                r_resp_rdata   <= w_illegal ? '0 : w_old;
            end
        end
    end

    assign bus.req_ready    = w_req_ready;
    assign bus.resp_valid   = r_resp_valid;
    assign bus.resp_rdata   = r_resp_rdata;
    assign bus.resp_illegal = r_resp_illegal;

    // ---------------- counters ----------------
`ifdef CSR_COUNTERS_EN
    logic [2*XLEN-1:0] w_mcycle;
    logic [2*XLEN-1:0] w_minstret;
    logic              w_sel_hit;
    logic [XLEN-1:0]   w_sel_val;
    logic              r_cnt_hit;
    logic [XLEN-1:0]   r_cnt_val;

    csr_counter64 #(.HALF_W(XLEN)) u_mcycle (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (1'b1),
        .i_wr_lo (w_we && (r_addr == ADDR_W'(CSR_MCYCLE))),
        .i_wr_hi (w_we && (r_addr == ADDR_W'(CSR_MCYCLEH))),
        .i_wdata (w_new),
        .o_cnt   (w_mcycle)
    );

    csr_counter64 #(.HALF_W(XLEN)) u_minstret (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (instret_inc),
        .i_wr_lo (w_we && (r_addr == ADDR_W'(CSR_MINSTRET))),
        .i_wr_hi (w_we && (r_addr == ADDR_W'(CSR_MINSTRETH))),
        .i_wdata (w_new),
        .o_cnt   (w_minstret)
    );

    // Counter reads are snapshotted at accept, mirroring the storage read timing
    always_comb begin
        w_sel_hit = 1'b1;
        w_sel_val = '0;
        case (bus.req_addr)
            ADDR_W'(CSR_MCYCLE),   ADDR_W'(CSR_CYCLE):   w_sel_val = w_mcycle[XLEN-1:0];
            ADDR_W'(CSR_MCYCLEH),  ADDR_W'(CSR_CYCLEH):  w_sel_val = w_mcycle[2*XLEN-1:XLEN];
            ADDR_W'(CSR_MINSTRET), ADDR_W'(CSR_INSTRET): w_sel_val = w_minstret[XLEN-1:0];
            ADDR_W'(CSR_MINSTRETH),ADDR_W'(CSR_INSTRETH):w_sel_val = w_minstret[2*XLEN-1:XLEN];
            default:                                     w_sel_hit = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt_hit <= 1'b0;
            r_cnt_val <= '0;
        end else if (w_accept) begin
            r_cnt_hit <= w_sel_hit;
            r_cnt_val <= w_sel_val;
        end
    end

    assign w_cnt_hit = r_cnt_hit;
    assign w_cnt_val = r_cnt_val;
`else
    assign w_cnt_hit = 1'b0;
    assign w_cnt_val = '0;
`endif

    // Address bits between the index and the region bits only matter for counter decode
    assign w_unused_ok = ^{instret_inc, r_addr, bus.req_addr};

endmodule

// File: tb/tb_csr_bank.sv
module tb_csr_bank;
    import csr_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic instret_inc = 1'b0;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        ill;
        bit          chk_data;
        int          cyc;
        string       tag;
    } exp_t;
    exp_t sb[$];

    csr_bank_if #(.XLEN(32), .ADDR_W(12)) bus ();

    csr_bank #(.XLEN(32), .ADDR_W(12), .DEPTH_LOG2(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .instret_inc (instret_inc),
        .bus         (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Response monitor: every resp_valid pulse must match the oldest outstanding expectation
    always @(negedge clk) begin : mon
        exp_t e;
        if (bus.resp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("spurious_resp", {31'b0, bus.resp_valid}, 32'd0);
            end else begin
                e = sb.pop_front();
                if (e.chk_data)
                    chk({e.tag, "_rdata"}, bus.resp_rdata, e.rdata);
                chk({e.tag, "_illegal"}, {31'b0, bus.resp_illegal}, {31'b0, e.ill});
                chk({e.tag, "_latency"}, 32'(cyc), 32'(e.cyc + 2));
            end
        end
    end

    function automatic exp_t mk(input logic [31:0] rd, input logic ill, input bit cd, input string tag);
        exp_t e;
        e.rdata = rd; e.ill = ill; e.chk_data = cd; e.cyc = cyc; e.tag = tag;
        return e;
    endfunction

    // Called at a negedge; presents one request until accepted, recording the expected response
    task automatic req(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rd, input logic exp_ill, input bit cd, input string tag);
        int waited;
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        waited = 0;
        while (bus.req_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 20)
            chk({tag, "_accept_timeout"}, {31'b0, bus.req_ready}, 32'd1);
        else
            sb.push_back(mk(exp_rd, exp_ill, cd, tag));
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_op    = 2'b00;
        bus.req_addr  = '0;
        bus.req_wdata = '0;

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ready",   {31'b0, bus.req_ready},    32'd1);
        chk("rst_valid",   {31'b0, bus.resp_valid},   32'd0);
        chk("rst_rdata",   bus.resp_rdata,            32'd0);
        chk("rst_illegal", {31'b0, bus.resp_illegal}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic RMW sequence on 0x340
        req(CSR_OP_RW, 12'h340, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0, "rw_340");
        req(CSR_OP_RS, 12'h340, 32'h0,        32'hDEADBEEF, 1'b0, 1'b1, "rs0_340");
        req(CSR_OP_RS, 12'h340, 32'h000000F0, 32'hDEADBEEF, 1'b0, 1'b1, "rs_f0");
        req(CSR_OP_RC, 12'h340, 32'hDEAD0000, 32'hDEADBEFF, 1'b0, 1'b1, "rc_dead");
        req(CSR_OP_RS, 12'h340, 32'h0,        32'h0000BEFF, 1'b0, 1'b1, "rd_340");
        drain();
        chk("hold_rdata", bus.resp_rdata,          32'h0000BEFF);
        chk("hold_valid", {31'b0, bus.resp_valid}, 32'd0);

        // Read-only region and reserved op
        req(CSR_OP_RW, 12'hC00, 32'h1, 32'h0, 1'b1, 1'b1, "rw_rom");
        drain();
        chk("hold_illegal", {31'b0, bus.resp_illegal}, 32'd1);
        req(CSR_OP_RS, 12'hC00, 32'h0,    32'h0,        1'b0, 1'b0, "rs0_rom");
        req(CSR_OP_RC, 12'hC00, 32'h0,    32'h0,        1'b0, 1'b0, "rc0_rom");
        req(CSR_OP_RW, 12'hC00, 32'h0,    32'h0,        1'b1, 1'b1, "rw0_rom");
        req(2'b00,     12'h340, 32'h1234, 32'h0,        1'b1, 1'b1, "op00");
        req(CSR_OP_RS, 12'h340, 32'h0,    32'h0000BEFF, 1'b0, 1'b1, "after_op00");
        req(CSR_OP_RS, 12'h140, 32'h0,    32'h0000BEFF, 1'b0, 1'b1, "alias_140");
        drain();

        // Back-to-back with req_valid held high
        bus.req_valid = 1'b1;
        bus.req_op    = CSR_OP_RS;
        bus.req_addr  = 12'h340;
        bus.req_wdata = 32'h0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("b2b_ready%0d", i), {31'b0, bus.req_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
            if (bus.req_ready === 1'b1)
                sb.push_back(mk(32'h0000BEFF, 1'b0, 1'b1, $sformatf("b2b%0d", i)));
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        drain();

        // Reset during EXEC aborts the write and suppresses the response
        req(CSR_OP_RW, 12'h341, 32'h11, 32'h0, 1'b0, 1'b0, "rw_341");
        drain();
        bus.req_valid = 1'b1;
        bus.req_op    = CSR_OP_RW;
        bus.req_addr  = 12'h341;
        bus.req_wdata = 32'h55;
        chk("abort_accept_ready", {31'b0, bus.req_ready}, 32'd1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("abort_in_exec", {31'b0, bus.req_ready}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_valid",   {31'b0, bus.resp_valid},   32'd0);
        chk("abort_rdata",   bus.resp_rdata,            32'd0);
        chk("abort_illegal", {31'b0, bus.resp_illegal}, 32'd0);
        chk("abort_ready",   {31'b0, bus.req_ready},    32'd1);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_no_resp", {31'b0, bus.resp_valid}, 32'd0);
        req(CSR_OP_RS, 12'h341, 32'h0, 32'h11, 1'b0, 1'b1, "after_abort");
        drain();

`ifdef CSR_COUNTERS_EN
        req(CSR_OP_RS, 12'hC82, 32'h0, 32'h0, 1'b0, 1'b1, "instreth_after_rst");
        req(CSR_OP_RS, 12'hC02, 32'h0, 32'h0, 1'b0, 1'b1, "instret_after_rst");
        req(CSR_OP_RS, 12'hC80, 32'h0, 32'h0, 1'b0, 1'b1, "cycleh_after_rst");
        drain();
        instret_inc = 1'b1;
        repeat (5) @(negedge clk);
        instret_inc = 1'b0;
        req(CSR_OP_RS, 12'hC02, 32'h0,  32'd5,   1'b0, 1'b1, "instret_5");
        req(CSR_OP_RW, 12'hB02, 32'd100, 32'd5,  1'b0, 1'b1, "rw_minstret");
        drain();
        req(CSR_OP_RS, 12'hC02, 32'h0,  32'd100, 1'b0, 1'b1, "instret_written");
        req(CSR_OP_RW, 12'hC02, 32'h1,  32'h0,   1'b1, 1'b1, "rw_instret_rom");
        req(CSR_OP_RW, 12'hB80, 32'h0,  32'h0,   1'b0, 1'b1, "rw_mcycleh");
        req(CSR_OP_RW, 12'hB00, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0, "rw_mcycle_lo");
        drain();
        req(CSR_OP_RS, 12'hB80, 32'h0,  32'd1,   1'b0, 1'b1, "mcycleh_wrap");
        req(CSR_OP_RS, 12'hC80, 32'h0,  32'd1,   1'b0, 1'b1, "cycleh_wrap");
        drain();
`else
        instret_inc = 1'b1;
        req(CSR_OP_RW, 12'hB80, 32'h7, 32'h0, 1'b0, 1'b0, "rw_b80");
        req(CSR_OP_RS, 12'hB80, 32'h0, 32'h7, 1'b0, 1'b1, "rd_b80");
        instret_inc = 1'b0;
        req(CSR_OP_RW, 12'hC02, 32'h1, 32'h0, 1'b1, 1'b1, "rw_c02_rom");
        drain();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
